// File: rtl/slot_alloc_64.sv
// slot_alloc_64: free-slot tracker for a 64-entry queue.
// Offers the lowest free slot each cycle and takes single or bulk releases.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   alloc_vld/rdy/idx offer of the lowest free slot; vld&rdy takes it
//   rel_vld/rel_idx   single-slot release
//   rel_vec           bulk release mask (flush)
//   free_vec          registered free map (1 = free)
//   free_cnt          registered popcount of free_vec
//   all_free          registered, free_cnt == NUM_SLOTS
//   err_dbl_free      one-cycle pulse after an illegal release
module slot_alloc_64 #(
    parameter int NUM_SLOTS = 64,
    parameter int IDX_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 alloc_vld,
    input  logic                 alloc_rdy,
    output logic [IDX_W-1:0]     alloc_idx,
    input  logic                 rel_vld,
    input  logic [IDX_W-1:0]     rel_idx,
    input  logic [NUM_SLOTS-1:0] rel_vec,
    output logic [NUM_SLOTS-1:0] free_vec,
    output logic [IDX_W:0]       free_cnt,
    output logic                 all_free,
    output logic                 err_dbl_free
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [NUM_SLOTS-1:0] ONE = NUM_SLOTS'(1);

    logic [NUM_SLOTS-1:0] free_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 all_free_q;
    logic                 err_q;

    logic [IDX_W-1:0]     pick_idx;
    logic                 alloc_fire;
    logic [NUM_SLOTS-1:0] alloc_oh;
    logic [NUM_SLOTS-1:0] rel_oh;
    logic [NUM_SLOTS-1:0] rel_mask;
    logic [NUM_SLOTS-1:0] rel_bad;
    logic [NUM_SLOTS-1:0] rel_ok;
    logic [NUM_SLOTS-1:0] free_d;
    logic [CNT_W-1:0]     cnt_d;

    // Lowest set bit wins: scan downward so the last hit is the smallest.
    always_comb begin
        pick_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_q[i]) pick_idx = IDX_W'(i);
        end
    end

    assign alloc_vld  = |free_q;
    assign alloc_idx  = pick_idx;
    assign alloc_fire = alloc_vld & alloc_rdy;
    assign alloc_oh   = alloc_fire ? (ONE << pick_idx) : '0;

    assign rel_oh   = rel_vld ? (ONE << rel_idx) : '0;
    assign rel_mask = rel_oh | rel_vec;

    // A release is illegal if the slot is already free, or is the slot
    // being granted this very cycle. Illegal bits are dropped, legal
    // bits of the same mask still apply.
    assign rel_bad = rel_mask & (free_q | alloc_oh);
    assign rel_ok  = rel_mask & ~rel_bad;
    assign free_d  = (free_q & ~alloc_oh) | rel_ok;

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt_d = cnt_d + CNT_W'(free_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_q     <= '1;
            cnt_q      <= CNT_W'(NUM_SLOTS);
            all_free_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            free_q     <= free_d;
            cnt_q      <= cnt_d;
            all_free_q <= (cnt_d == CNT_W'(NUM_SLOTS));
            err_q      <= |rel_bad;
        end
    end

    assign free_vec     = free_q;
    assign free_cnt     = cnt_q;
    assign all_free     = all_free_q;
    assign err_dbl_free = err_q;

endmodule

// File: tb/tb_slot_alloc_64.sv
// tb_slot_alloc_64: directed self-checking bench for slot_alloc_64.
// Linear stimulus with immediate assertions at each check point.
module tb_slot_alloc_64;

    logic        clk;
    logic        rst;
    logic        alloc_vld;
    logic        alloc_rdy;
    logic [5:0]  alloc_idx;
    logic        rel_vld;
    logic [5:0]  rel_idx;
    logic [63:0] rel_vec;
    logic [63:0] free_vec;
    logic [6:0]  free_cnt;
    logic        all_free;
    logic        err_dbl_free;

    int npass;
    int ntotal;

    slot_alloc_64 #(.NUM_SLOTS(64), .IDX_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_vld    (alloc_vld),
        .alloc_rdy    (alloc_rdy),
        .alloc_idx    (alloc_idx),
        .rel_vld      (rel_vld),
        .rel_idx      (rel_idx),
        .rel_vec      (rel_vec),
        .free_vec     (free_vec),
        .free_cnt     (free_cnt),
        .all_free     (all_free),
        .err_dbl_free (err_dbl_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        npass     = 0;
        ntotal    = 0;
        rst       = 1'b1;
        alloc_rdy = 1'b0;
        rel_vld   = 1'b0;
        rel_idx   = '0;
        rel_vec   = '0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_free_vec", free_vec, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_free_cnt", free_cnt, 64);
        check("rst_all_free", all_free, 1);
        check("rst_err", err_dbl_free, 0);
        check("rst_alloc_vld", alloc_vld, 1);
        check("rst_alloc_idx", alloc_idx, 0);

        // Drain all 64 slots in order
        alloc_rdy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            check("drain_idx", alloc_idx, i);
            check("drain_cnt", free_cnt, 64 - i);
            step();
        end
        check("full_vld", alloc_vld, 0);
        check("full_idx", alloc_idx, 0);
        check("full_cnt", free_cnt, 0);
        check("full_all_free", all_free, 0);
        check("full_vec", free_vec, 0);

        // rdy while full is ignored
        step();
        check("full_rdy_cnt", free_cnt, 0);
        check("full_rdy_err", err_dbl_free, 0);

        // Single release of 37 while full
        alloc_rdy = 1'b0;
        rel_vld   = 1'b1;
        rel_idx   = 6'd37;
        step();
        rel_vld = 1'b0;
        check("rel37_vld", alloc_vld, 1);
        check("rel37_idx", alloc_idx, 37);
        check("rel37_cnt", free_cnt, 1);
        check("rel37_err", err_dbl_free, 0);

        // Take 37 back to full
        alloc_rdy = 1'b1;
        step();
        alloc_rdy = 1'b0;
        check("retake37_cnt", free_cnt, 0);

        // Bulk flush of the top 16 slots
        rel_vec = 64'hFFFF_0000_0000_0000;
        step();
        rel_vec = '0;
        check("flush_cnt", free_cnt, 16);
        check("flush_idx", alloc_idx, 48);
        check("flush_vec", free_vec, 64'hFFFF_0000_0000_0000);

        // Double free: slots 0-3 busy, release 5
        rst = 1'b1;
        step();
        rst = 1'b0;
        alloc_rdy = 1'b1;
        repeat (4) step();
        alloc_rdy = 1'b0;
        check("busy4_cnt", free_cnt, 60);
        rel_vld = 1'b1;
        rel_idx = 6'd5;
        step();
        rel_vld = 1'b0;
        check("dbl_err", err_dbl_free, 1);
        check("dbl_vec", free_vec, ~64'hF);
        check("dbl_cnt", free_cnt, 60);
        step();
        check("dbl_err_pulse", err_dbl_free, 0);

        // Slots 0-9 busy, alloc 10 and release 2 together
        alloc_rdy = 1'b1;
        repeat (6) step();
        check("busy10_cnt", free_cnt, 54);
        check("busy10_idx", alloc_idx, 10);
        rel_vld = 1'b1;
        rel_idx = 6'd2;
        step();
        check("swap_vec", free_vec, ~64'h7FB);
        check("swap_cnt", free_cnt, 54);
        check("swap_idx", alloc_idx, 2);
        check("swap_err", err_dbl_free, 0);

        // Release of the slot granted in the same cycle is illegal
        step();
        alloc_rdy = 1'b0;
        rel_vld   = 1'b0;
        check("same_err", err_dbl_free, 1);
        check("same_vec", free_vec, ~64'h7FF);
        check("same_cnt", free_cnt, 53);

        // Overlap of legal bits counts once, no error
        rel_vld = 1'b1;
        rel_idx = 6'd3;
        rel_vec = 64'h9;
        step();
        rel_vld = 1'b0;
        check("ovl_err", err_dbl_free, 0);
        check("ovl_vec", free_vec, ~64'h7F6);
        check("ovl_cnt", free_cnt, 55);
        check("ovl_idx", alloc_idx, 0);

        // Mixed mask: bit 20 illegal, bit 4 legal
        rel_vec = 64'h0010_0010;
        step();
        rel_vec = '0;
        check("mix_err", err_dbl_free, 1);
        check("mix_vec", free_vec, ~64'h7E6);
        check("mix_cnt", free_cnt, 56);

        // Reset mid-burst overrides alloc, release and pending error
        rel_vec   = 64'h0010_0000;
        alloc_rdy = 1'b1;
        step();
        rel_vec = '0;
        rel_vld = 1'b1;
        rel_idx = 6'd7;
        rst     = 1'b1;
        step();
        rst       = 1'b0;
        rel_vld   = 1'b0;
        alloc_rdy = 1'b0;
        check("mid_rst_vec", free_vec, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mid_rst_cnt", free_cnt, 64);
        check("mid_rst_err", err_dbl_free, 0);
        check("mid_rst_all", all_free, 1);
        check("mid_rst_idx", alloc_idx, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
